alu_ex_stage: RTL

//   Execute stage of the 32-bit pipeline: takes the ID/EX operand bundle, resolves

---
 rtl/alu_ex_stage.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage -- execute stage of the 32-bit pipeline.
//
// Takes the ID/EX operand bundle and resolves operand forwarding from the
// EX/MEM register and the writeback port. It drives a single `alu` instance
// and registers the result and flags into EX/MEM for the memory stage.
// Stall and flush controls and an overflow-trap state machine for signed ops
// are included.
//
// Operand and data buses are declared [0:31] (bit 0 is the MSB). Arithmetic
// treats them as ordinary 32-bit numbers.
//
// Parameters
//   TRAP_ON_OF : 1 = signed overflow on an id_ovf_chk op suppresses writeback
//                and raises trap
//   FWD_EN     : 1 = forwarding muxes active, 0 = id_a/id_b used unmodified
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   id_valid/id_ready   ID/EX handshake (id_ready is combinational)
//   id_a, id_b          operands [0:31]
//   id_ctrl             ALU opcode, passed to alu.ctrl unmodified
//   id_rs1, id_rs2      forwarding tags of A / B
//   id_rd               destination register
//   id_ovf_chk          op is signed, so overflow is a trap condition
//   stall, flush        hazard unit controls
//   wb_valid/rd/data    writeback port used as the second forwarding source
//   ex_valid            EX/MEM holds an instruction that must write back
//   ex_result/zero/of   registered alu outputs
//   ex_rd               registered destination register
//   trap, trap_ack      overflow trap request and acknowledge
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// alu -- combinational 32-bit ALU.
//   ctrl 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
//   Any other code yields out=0.
//   of is signed overflow for ADD/SUB and 0 for every other op.
//   zero is asserted when out==0.
// -----------------------------------------------------------------------------
module alu (
  input  logic [0:31] a,
  input  logic [0:31] b,
  input  logic [3:0]  ctrl,
  output logic [0:31] out,
  output logic        zero,
  output logic        of
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [0:31] sum_s;
  logic [0:31] diff_s;
  logic        slt_s;

  // Operation select and signed-overflow detection; bit 0 is the sign bit.
  always_comb begin
    sum_s  = a + b;
    diff_s = a - b;
    slt_s  = ($signed(a) < $signed(b));
    out    = 32'd0;
    of     = 1'b0;
    case (ctrl)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: begin
        out = sum_s;
        of  = (a[0] == b[0]) && (sum_s[0] != a[0]);
      end
      ALU_SUB: begin
        out = diff_s;
        of  = (a[0] != b[0]) && (diff_s[0] != a[0]);
      end
      ALU_SLT: out = {31'd0, slt_s};
      ALU_NOR: out = ~(a | b);
      default: begin
        out = 32'd0;
        of  = 1'b0;
      end
    endcase
  end

  assign zero = (out == 32'd0);

endmodule

module alu_ex_stage #(
  parameter logic TRAP_ON_OF = 1'b1,
  parameter logic FWD_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [0:31] id_a,
  input  logic [0:31] id_b,
  input  logic [3:0]  id_ctrl,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_ovf_chk,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [0:31] wb_data,
  output logic        ex_valid,
  output logic [0:31] ex_result,
  output logic        ex_zero,
  output logic        ex_of,
  output logic [4:0]  ex_rd,
  output logic        trap,
  input  logic        trap_ack
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  logic [0:0]  state_r;
  logic        trap_r;
  logic        ex_valid_r;
  logic [0:31] ex_result_r;
  logic        ex_zero_r;
  logic        ex_of_r;
  logic [4:0]  ex_rd_r;

  logic [0:31] op_a_s;
  logic [0:31] op_b_s;
  logic [0:31] alu_out_s;
  logic        alu_zero_s;
  logic        alu_of_s;
  logic        ready_s;
  logic        accept_s;
  logic        trap_take_s;

  assign ready_s  = (state_r == ST_RUN) && !stall;
  assign id_ready = ready_s;

  // Forwarding for operand A. EX/MEM beats writeback, and register 0 never forwards.
  always_comb begin
    op_a_s = id_a;
    if (FWD_EN && (id_rs1 != 5'd0) && ex_valid_r && (ex_rd_r == id_rs1)) begin
      op_a_s = ex_result_r;
    end else if (FWD_EN && (id_rs1 != 5'd0) && wb_valid && (wb_rd == id_rs1)) begin
      op_a_s = wb_data;
    end else begin
      op_a_s = id_a;
    end
  end

  // Forwarding for operand B, with the same priority as A.
  always_comb begin
    op_b_s = id_b;
    if (FWD_EN && (id_rs2 != 5'd0) && ex_valid_r && (ex_rd_r == id_rs2)) begin
      op_b_s = ex_result_r;
    end else if (FWD_EN && (id_rs2 != 5'd0) && wb_valid && (wb_rd == id_rs2)) begin
      op_b_s = wb_data;
    end else begin
      op_b_s = id_b;
    end
  end

  alu u_alu (
    .a    (op_a_s),
    .b    (op_b_s),
    .ctrl (id_ctrl),
    .out  (alu_out_s),
    .zero (alu_zero_s),
    .of   (alu_of_s)
  );

  assign accept_s    = id_valid && ready_s && !flush;
  assign trap_take_s = accept_s && TRAP_ON_OF && id_ovf_chk && alu_of_s;

  // EX/MEM register: flush kills ex_valid even under stall or trap, while
  // stall and TRAP hold everything. A trapping op still records its result
  // and flags, but it is marked as not writing back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r  <= 1'b0;
      ex_result_r <= 32'd0;
      ex_zero_r   <= 1'b0;
      ex_of_r     <= 1'b0;
      ex_rd_r     <= 5'd0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (ready_s) begin
      if (id_valid) begin
        ex_valid_r  <= !trap_take_s;
        ex_result_r <= alu_out_s;
        ex_zero_r   <= alu_zero_s;
        ex_of_r     <= alu_of_s;
        ex_rd_r     <= id_rd;
      end else begin
        ex_valid_r <= 1'b0;
      end
    end
  end

  // Trap state machine. Flush does not affect it, and trap_ack is only
  // honoured while in TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      trap_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (trap_take_s) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            state_r <= ST_RUN;
            trap_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_RUN;
          trap_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ex_valid  = ex_valid_r;
  assign ex_result = ex_result_r;
  assign ex_zero   = ex_zero_r;
  assign ex_of     = ex_of_r;
  assign ex_rd     = ex_rd_r;
  assign trap      = trap_r;

endmodule
